// File: rtl/alu_pkg.sv
// Shared widths, alu_ctrl encodings and the registered NZCV flag bundle for alu_16bits.
package alu_pkg;

    localparam int unsigned ALU_W = 16;

    // alu_ctrl[1] = comp_e (carry-in from sign), alu_ctrl[0] = sign (subtract, invert B)
    localparam logic [1:0] ALU_ADC = 2'b00;
    localparam logic [1:0] ALU_SBC = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_SUB = 2'b11;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/alu_cla4.sv
// 4-bit carry-lookahead slice; also exports the carry into bit 3 for overflow detection.
module alu_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       c3
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // All internal carries flattened from generate/propagate terms
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s  = p ^ c;
    assign c3 = c[3];

endmodule

// File: rtl/alu_16bits.sv
// 16-bit add/subtract ALU with multi-word carry chaining and registered NZCV flags.
// ALU_16BITS_CLA_EN selects a 4x4-bit carry-lookahead adder instead of ripple carry.
module alu_16bits
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       alu_ctrl,
    input  logic             c_pre,
    output logic [WIDTH-1:0] s,
    output logic             z,
    output logic             c,
    output logic             n,
    output logic             v
);

    logic             sign;
    logic             comp_e;
    logic [WIDTH-1:0] b_eff;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             c_msb;

    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] s_q;
    alu_flags_t       flags_d;
    alu_flags_t       flags_q;

    assign sign   = alu_ctrl[0];
    assign comp_e = alu_ctrl[1];
    assign b_eff  = b ^ {WIDTH{sign}};
    // With comp_e set the carry-in follows sign, so c_pre is never observed
    assign cin    = comp_e ? sign : c_pre;

`ifdef ALU_16BITS_CLA_EN
    localparam int unsigned NSLICE = WIDTH / 4;

    logic [NSLICE:0]   blk_c;
    logic [NSLICE-1:0] blk_c3;
    logic [NSLICE-2:0] c3_unused;

    assign blk_c[0] = cin;

    for (genvar i = 0; i < NSLICE; i++) begin : g_cla
        alu_cla4 u_cla4 (
            .a  (a[4*i +: 4]),
            .b  (b_eff[4*i +: 4]),
            .ci (blk_c[i]),
            .s  (sum[4*i +: 4]),
            .co (blk_c[i+1]),
            .c3 (blk_c3[i])
        );
    end

    assign cout      = blk_c[NSLICE];
    assign c_msb     = blk_c3[NSLICE-1];
    assign c3_unused = blk_c3[NSLICE-2:0];
`else
    logic [WIDTH:0] rc;

    assign rc[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b_eff[i] ^ rc[i];
        assign rc[i+1] = (a[i] & b_eff[i]) | (rc[i] & (a[i] ^ b_eff[i]));
    end

    assign cout  = rc[WIDTH];
    assign c_msb = rc[WIDTH-1];
`endif

    // Flags from this cycle's sum; v = c16 ^ c15 equals the sign-rule overflow
    always_comb begin
        s_d       = sum;
        flags_d   = '0;
        flags_d.n = sum[WIDTH-1];
        flags_d.z = (sum == '0);
        flags_d.c = cout;
        flags_d.v = cout ^ c_msb;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q     <= '0;
            flags_q <= '0;
        end else begin
            s_q     <= s_d;
            flags_q <= flags_d;
        end
    end

    assign s = s_q;
    assign n = flags_q.n;
    assign z = flags_q.z;
    assign c = flags_q.c;
    assign v = flags_q.v;

endmodule

// File: tb/tb_alu_16bits.sv
// Directed and random checks of alu_16bits against a 17-bit arithmetic reference.
module tb_alu_16bits;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  alu_ctrl;
    logic        c_pre;
    logic [15:0] s;
    logic        z;
    logic        c;
    logic        n;
    logic        v;

    int checks   = 0;
    int failures = 0;

    alu_16bits dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .alu_ctrl (alu_ctrl),
        .c_pre    (c_pre),
        .s        (s),
        .z        (z),
        .c        (c),
        .n        (n),
        .v        (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference packed as {s[15:0], n, z, c, v}
    function automatic logic [19:0] ref_model(input logic [1:0] ctrl, input logic [15:0] aa,
                                              input logic [15:0] bb, input logic cp);
        logic [15:0] be;
        logic        ci;
        logic [16:0] r;
        logic        ov;
        be = ctrl[0] ? ~bb : bb;
        ci = ctrl[1] ? ctrl[0] : cp;
        r  = {1'b0, aa} + {1'b0, be} + {16'd0, ci};
        ov = (aa[15] == be[15]) && (r[15] != aa[15]);
        return {r[15:0], r[15], (r[15:0] == 16'd0), r[16], ov};
    endfunction

    task automatic drive(input logic [1:0] ctrl, input logic [15:0] aa,
                         input logic [15:0] bb, input logic cp);
        alu_ctrl = ctrl;
        a        = aa;
        b        = bb;
        c_pre    = cp;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [15:0] es, input logic en,
                              input logic ez, input logic ec, input logic ev);
        logic [19:0] obs;
        logic [19:0] exp_v;
        obs   = {s, n, z, c, v};
        exp_v = {es, en, ez, ec, ev};
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s: got s=%h nzcv=%b expected s=%h nzcv=%b",
                   tag, obs[19:4], obs[3:0], exp_v[19:4], exp_v[3:0]);
        end
    endtask

    initial begin
        logic [19:0] r;
        rst = 1'b1;
        drive(ALU_ADD, 16'hFFFF, 16'hFFFF, 1'b1);
        tick();
        expect_out("reset_init", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("reset_hold", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        drive(ALU_ADD, 16'h7FFF, 16'h0001, 1'b0);
        tick();
        expect_out("add_overflow", 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1);

        drive(ALU_SUB, 16'h0005, 16'h0005, 1'b0);
        tick();
        expect_out("sub_equal", 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);

        drive(ALU_ADC, 16'hFFFF, 16'h0001, 1'b0);
        tick();
        expect_out("adc_wrap_c0", 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);

        drive(ALU_ADC, 16'hFFFF, 16'h0001, 1'b1);
        tick();
        expect_out("adc_wrap_c1", 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);

        drive(ALU_SBC, 16'h0005, 16'h0003, 1'b0);
        tick();
        expect_out("sbc_borrow", 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);

        drive(ALU_SBC, 16'h0005, 16'h0003, 1'b1);
        tick();
        expect_out("sbc_noborrow", 16'h0002, 1'b0, 1'b0, 1'b1, 1'b0);

        drive(ALU_SUB, 16'h8000, 16'h0001, 1'b0);
        tick();
        expect_out("sub_overflow", 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b1);

        drive(ALU_SUB, 16'h0000, 16'h0001, 1'b1);
        tick();
        expect_out("sub_borrow", 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);

        drive(ALU_ADD, 16'h1234, 16'h4321, 1'b1);
        tick();
        expect_out("add_ignores_cpre", 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);

        drive(ALU_SUB, 16'h0003, 16'h0001, 1'bx);
        tick();
        expect_out("sub_cpre_x", 16'h0002, 1'b0, 1'b0, 1'b1, 1'b0);

        // Back-to-back ops then a one-edge reset that swallows the op presented with it
        drive(ALU_ADD, 16'h0001, 16'h0002, 1'b0);
        tick();
        expect_out("stream_pre_rst", 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        drive(ALU_SUB, 16'h0009, 16'h0004, 1'b0);
        tick();
        expect_out("reset_mid", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        drive(ALU_ADD, 16'h0010, 16'h0020, 1'b0);
        tick();
        expect_out("post_rst_op", 16'h0030, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 240; i++) begin
            logic [1:0]  rc;
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rcp;
            rc  = 2'($urandom_range(3, 0));
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rcp = 1'($urandom_range(1, 0));
            if (i % 16 == 0) ra = 16'hFFFF;
            if (i % 16 == 1) rb = 16'h8000;
            drive(rc, ra, rb, rcp);
            r = ref_model(rc, ra, rb, rcp);
            tick();
            expect_out("random", r[19:4], r[3], r[2], r[1], r[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
